forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
//  Control end of the EX-stage operand path. Drives the 2-bit selects of the two 3-input operand muxes
//  (00 = register file, 01 = MEM/WB writeback, 1x = EX/MEM ALU result).
//  Also owns the load-use stall and the multi-cycle multiplier stall, with its occupancy counter and FSM.
//  Sits beside ID/EX in the 5-stage pipeline.
//  Consumes pipeline-register fields; drives pipeline-register enables and flushes.
// PARAMETERS
//  REG_ADDR_W  5  width of register addresses
//  MULT_LAT    4  cycles a MUL instruction occupies EX (>=1)
// PORTS
//  clk               in   1           system clock, rising edge
//  arst              in   1           asynchronous reset, active-high
//  id_ex_rs1         in   REG_ADDR_W  source 1 of instr in EX
//  id_ex_rs2         in   REG_ADDR_W  source 2 of instr in EX
//  id_ex_rd          in   REG_ADDR_W  destination of instr in EX
//  id_ex_mem_read    in   1           instr in EX is a load
//  id_ex_is_mult     in   1           instr in EX is a MUL
//  if_id_rs1         in   REG_ADDR_W  source 1 of instr in ID
//  if_id_rs2         in   REG_ADDR_W  source 2 of instr in ID
//  ex_mem_rd         in   REG_ADDR_W  destination in EX/MEM
//  ex_mem_reg_write  in   1           EX/MEM writes register file
//  mem_wb_rd         in   REG_ADDR_W  destination in MEM/WB
//  mem_wb_reg_write  in   1           MEM/WB writes register file
//  fwd_a_sel         out  2           operand-A mux select
//  fwd_b_sel         out  2           operand-B mux select
//  pc_write          out  1           PC update enable
//  if_id_write       out  1           IF/ID update enable
//  id_ex_write       out  1           ID/EX update enable (held during MUL)
//  id_ex_flush       out  1           load bubble into ID/EX
//  ex_mem_bubble     out  1           load bubble into EX/MEM
//  mult_busy         out  1           FSM in MUL_BUSY
// BEHAVIOUR
//  Forwarding (combinational). Per operand, the EX/MEM match wins:
//   - EX/MEM match: ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==rsX -> 2'b10.
//   - else MEM/WB match: mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==rsX -> 2'b01.
//   - else 2'b00.
//   - Register 0 never forwards.
//   - Selects are valid in the first EX cycle of every instr; the multiplier samples its operands then.
//  FSM states IDLE, MUL_BUSY; cnt = clog2(MULT_LAT)-bit counter.
//   - IDLE & id_ex_is_mult & MULT_LAT>1 -> MUL_BUSY, cnt<=1.
//   - MUL_BUSY & cnt<MULT_LAT-1 -> cnt++.
//   - MUL_BUSY & cnt==MULT_LAT-1 -> IDLE, cnt<=0.
//  mult_stall = id_ex_is_mult & !(state==MUL_BUSY & cnt==MULT_LAT-1); with MULT_LAT==1 it is 0.
//   - A MUL holds EX for exactly MULT_LAT cycles, i.e. MULT_LAT-1 stall cycles.
//   - A back-to-back MUL re-enters MUL_BUSY from IDLE the next cycle.
//  load_stall = id_ex_mem_read & id_ex_rd!=0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2).
//   - Lasts 1 cycle; mutually exclusive with mult_stall (one instr in ID/EX).
//  Outputs:
//   - pc_write = if_id_write = !(mult_stall|load_stall)
//   - id_ex_write = !mult_stall
//   - id_ex_flush = load_stall
//   - ex_mem_bubble = mult_stall, so the partial MUL never reaches MEM
//  Reset: arst forces state=IDLE, cnt=0 immediately.
//   - Outputs then follow the inputs combinationally.
//   - With all inputs 0: sel=00, write enables=1, flush/bubble/mult_busy=0.
//   - arst mid-MUL aborts the count; a MUL still in EX after release restarts the count from 0.
// STRUCTURE
//  Shared package: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FSM state encodings.
//  Sub-module mult_latency_counter holds the FSM and cnt.
//   - Ports: clk, arst, start, busy, last.
//  The top level holds the forwarding compares and the stall/enable logic.
// TESTING
//  1. ex_mem rd=5 wr=1, mem_wb rd=5 wr=1, id_ex rs1=5 -> fwd_a_sel=10 (EX/MEM priority).
//  2. mem_wb rd=0 wr=1, rs2=0 -> fwd_b_sel=00; mem_wb rd=7, rs2=7 -> 01.
//  3. load id_ex_rd=3, if_id_rs2=3 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; then all normal.
//  4. MUL in EX at T0 (MULT_LAT=4) -> stall T0-T2 (pc_write=0, id_ex_write=0, ex_mem_bubble=1), T3 released.
//     - mult_busy=1 T1-T3.
//  5. Two consecutive MULs -> 6 stall cycles total, counter restarts from IDLE.
//  6. arst pulse at T1 of a MUL -> state IDLE immediately; a MUL still present after release stalls 3 more cycles.

Source files
------------

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared encodings for the EX-stage forwarding/hazard unit: operand-mux selects and multiplier FSM states.
package forwarding_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MS_IDLE     = 1'b0,
        MS_MUL_BUSY = 1'b1
    } mult_state_e;

endpackage

// File: rtl/forwarding_hazard_unit_mult_cnt.sv
// Multiplier occupancy tracker: counts the cycles a MUL has spent in EX and flags its final cycle.
module mult_latency_counter
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic start,
    output logic busy,
    output logic last
);

    localparam int unsigned CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic MUL_MULTI = (MULT_LAT > 32'd1);

    mult_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;

    // Counter starts at 1 because the first EX cycle of the MUL is spent in IDLE.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= MS_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MS_IDLE: begin
                    if (start && MUL_MULTI) begin
                        r_state <= MS_MUL_BUSY;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                MS_MUL_BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= MS_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= MS_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state == MS_MUL_BUSY);
    assign last = busy && (r_cnt == CNT_LAST);

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selects plus load-use and multi-cycle MUL stall control for a 5-stage pipeline.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MULT_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REG_ADDR_W-1:0] id_ex_rs1,
    input  logic [REG_ADDR_W-1:0] id_ex_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_is_mult,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_reg_write,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_bubble,
    output logic                  mult_busy
);

    localparam logic MUL_MULTI = (MULT_LAT > 32'd1);

    logic w_mult_busy;
    logic w_mult_last;
    logic w_mult_stall;
    logic w_load_stall;

    // The younger result (EX/MEM) takes priority; r0 is hardwired zero and never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] em_rd,
        input logic                  em_wr,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_wr
    );
        if (em_wr && (em_rd != '0) && (em_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    mult_latency_counter #(
        .MULT_LAT (MULT_LAT)
    ) u_mult_cnt (
        .clk   (clk),
        .arst  (arst),
        .start (id_ex_is_mult),
        .busy  (w_mult_busy),
        .last  (w_mult_last)
    );

    always_comb begin
        w_mult_stall  = 1'b0;
        w_load_stall  = 1'b0;
        fwd_a_sel     = FWD_RF;
        fwd_b_sel     = FWD_RF;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mult_busy     = w_mult_busy;

        fwd_a_sel = fwd_select(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
        fwd_b_sel = fwd_select(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);

        w_mult_stall = MUL_MULTI && id_ex_is_mult && !w_mult_last;
        w_load_stall = id_ex_mem_read && (id_ex_rd != '0)
                       && ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

        pc_write      = !(w_mult_stall || w_load_stall);
        if_id_write   = !(w_mult_stall || w_load_stall);
        id_ex_write   = !w_mult_stall;
        id_ex_flush   = w_load_stall;
        ex_mem_bubble = w_mult_stall;
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: directed pipeline scenarios followed by constrained-random traffic.
module tb_forwarding_hazard_unit;

    localparam int unsigned AW       = 5;
    localparam int unsigned MULT_LAT = 4;

    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          mem_read;
        logic          is_mult;
        logic [AW-1:0] if_rs1;
        logic [AW-1:0] if_rs2;
        logic [AW-1:0] em_rd;
        logic          em_wr;
        logic [AW-1:0] wb_rd;
        logic          wb_wr;
    } in_t;

    typedef struct {
        int       cyc;
        int       fa;
        int       fb;
        bit       pcw;
        bit       ifw;
        bit       idw;
        bit       flush;
        bit       bubble;
        bit       busy;
    } exp_t;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [AW-1:0] id_ex_rs1 = '0, id_ex_rs2 = '0, id_ex_rd = '0;
    logic          id_ex_mem_read = 1'b0, id_ex_is_mult = 1'b0;
    logic [AW-1:0] if_id_rs1 = '0, if_id_rs2 = '0;
    logic [AW-1:0] ex_mem_rd = '0, mem_wb_rd = '0;
    logic          ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_bubble, mult_busy;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;
    int   m_age = 0;
    bit   m_last_stall = 1'b0;

    forwarding_hazard_unit #(
        .REG_ADDR_W (AW),
        .MULT_LAT   (MULT_LAT)
    ) dut (
        .clk              (clk),
        .arst             (arst),
        .id_ex_rs1        (id_ex_rs1),
        .id_ex_rs2        (id_ex_rs2),
        .id_ex_rd         (id_ex_rd),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_is_mult    (id_ex_is_mult),
        .if_id_rs1        (if_id_rs1),
        .if_id_rs2        (if_id_rs2),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .fwd_a_sel        (fwd_a_sel),
        .fwd_b_sel        (fwd_b_sel),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_write      (id_ex_write),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_bubble    (ex_mem_bubble),
        .mult_busy        (mult_busy)
    );

    always #5 clk = ~clk;

    // Reference: priority forwarding rule, plus "a MUL occupies EX for MULT_LAT cycles" as an age count.
    function automatic int exp_fwd(input int rs, input int em_rd, input bit em_wr, input int wb_rd, input bit wb_wr);
        if (em_wr && em_rd != 0 && em_rd == rs) return 2;
        if (wb_wr && wb_rd != 0 && wb_rd == rs) return 1;
        return 0;
    endfunction

    task automatic drive(input in_t s, input bit rst_pulse);
        exp_t e;
        bit   ms;
        bit   ld;
        @(posedge clk);
        #1;
        id_ex_rs1 = s.rs1;  id_ex_rs2 = s.rs2;  id_ex_rd = s.rd;
        id_ex_mem_read = s.mem_read;  id_ex_is_mult = s.is_mult;
        if_id_rs1 = s.if_rs1;  if_id_rs2 = s.if_rs2;
        ex_mem_rd = s.em_rd;  ex_mem_reg_write = s.em_wr;
        mem_wb_rd = s.wb_rd;  mem_wb_reg_write = s.wb_wr;
        if (rst_pulse) begin
            arst = 1'b1;
            #1;
            arst = 1'b0;
            m_age = 0;
        end
        ms = s.is_mult && (MULT_LAT > 1) && (m_age < int'(MULT_LAT) - 1);
        ld = s.mem_read && s.rd != 0 && (s.rd == s.if_rs1 || s.rd == s.if_rs2);
        e.cyc    = cyc_n;
        e.fa     = exp_fwd(int'(s.rs1), int'(s.em_rd), s.em_wr, int'(s.wb_rd), s.wb_wr);
        e.fb     = exp_fwd(int'(s.rs2), int'(s.em_rd), s.em_wr, int'(s.wb_rd), s.wb_wr);
        e.pcw    = !(ms || ld);
        e.ifw    = !(ms || ld);
        e.idw    = !ms;
        e.flush  = ld;
        e.bubble = ms;
        e.busy   = (m_age != 0);
        sb.push_back(e);
        cyc_n++;
        m_age = (s.is_mult && ms) ? m_age + 1 : 0;
        m_last_stall = ms;
    endtask

    task automatic chk(input int cyc, input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL cyc%0d %s: got %0d expected %0d", cyc, name, act, expv);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.cyc, "fwd_a_sel",     int'(fwd_a_sel),     e.fa);
            chk(e.cyc, "fwd_b_sel",     int'(fwd_b_sel),     e.fb);
            chk(e.cyc, "pc_write",      int'(pc_write),      int'(e.pcw));
            chk(e.cyc, "if_id_write",   int'(if_id_write),   int'(e.ifw));
            chk(e.cyc, "id_ex_write",   int'(id_ex_write),   int'(e.idw));
            chk(e.cyc, "id_ex_flush",   int'(id_ex_flush),   int'(e.flush));
            chk(e.cyc, "ex_mem_bubble", int'(ex_mem_bubble), int'(e.bubble));
            chk(e.cyc, "mult_busy",     int'(mult_busy),     int'(e.busy));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t z;
        in_t s;
        in_t prev;
        z = '0;

        // Reset held with all inputs idle.
        drive(z, 1'b0);
        @(negedge clk);
        #1 arst = 1'b0;

        // EX/MEM priority over MEM/WB on operand A.
        s = z; s.em_rd = 5'd5; s.em_wr = 1'b1; s.wb_rd = 5'd5; s.wb_wr = 1'b1; s.rs1 = 5'd5;
        drive(s, 1'b0);
        // r0 never forwards; then MEM/WB forward on operand B.
        s = z; s.wb_rd = 5'd0; s.wb_wr = 1'b1; s.rs2 = 5'd0;
        drive(s, 1'b0);
        s = z; s.wb_rd = 5'd7; s.wb_wr = 1'b1; s.rs2 = 5'd7;
        drive(s, 1'b0);
        // Load-use: one bubble cycle, then the flushed slot is empty.
        s = z; s.mem_read = 1'b1; s.rd = 5'd3; s.if_rs2 = 5'd3;
        drive(s, 1'b0);
        drive(z, 1'b0);
        // Single MUL held in EX.
        s = z; s.is_mult = 1'b1; s.rs1 = 5'd2; s.rs2 = 5'd4;
        for (int i = 0; i < int'(MULT_LAT); i++) drive(s, 1'b0);
        drive(z, 1'b0);
        // Two back-to-back MULs.
        for (int i = 0; i < 2 * int'(MULT_LAT); i++) drive(s, 1'b0);
        drive(z, 1'b0);
        // Reset in the second cycle of a MUL; the MUL stays in EX afterwards.
        drive(s, 1'b0);
        drive(s, 1'b1);
        for (int i = 0; i < int'(MULT_LAT) - 1; i++) drive(s, 1'b0);
        drive(z, 1'b0);

        // Random traffic; ID/EX fields are held while the unit stalls on a MUL.
        prev = z;
        for (int i = 0; i < 600; i++) begin
            s.rs1      = AW'($urandom_range(0, 7));
            s.rs2      = AW'($urandom_range(0, 7));
            s.rd       = AW'($urandom_range(0, 7));
            s.mem_read = ($urandom_range(0, 3) == 0);
            s.is_mult  = ($urandom_range(0, 4) == 0);
            s.if_rs1   = AW'($urandom_range(0, 7));
            s.if_rs2   = AW'($urandom_range(0, 7));
            s.em_rd    = AW'($urandom_range(0, 7));
            s.em_wr    = $urandom_range(0, 1) != 0;
            s.wb_rd    = AW'($urandom_range(0, 7));
            s.wb_wr    = $urandom_range(0, 1) != 0;
            if (s.is_mult) s.mem_read = 1'b0;
            if (m_last_stall) begin
                s.rs1 = prev.rs1; s.rs2 = prev.rs2; s.rd = prev.rd;
                s.mem_read = prev.mem_read; s.is_mult = prev.is_mult;
            end
            prev = s;
            drive(s, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
